traf_sensor_req: RTL

- Upstream request conditioner for the traffic-light controller (traf_rtl).
- Synchronises and debounces the raw side-road car sensor and the pedestrian button.
- Turns them into a clean, latched side-road request level and tracks how long that request has waited.
- Watches the controller's side-road light output to know when a request has been served.

---
 rtl/traf_pkg.sv | 7 +
 rtl/traf_debounce.sv | 36 +++
 rtl/traf_sensor_req.sv | 57 +++++
 3 files changed

// File: rtl/traf_pkg.sv
// traf_pkg: light encoding and request FSM states shared by the traffic-light blocks
package traf_pkg;
    localparam logic [1:0] LT_RED    = 2'b00;
    localparam logic [1:0] LT_YELLOW = 2'b01;
    localparam logic [1:0] LT_GREEN  = 2'b10;
    typedef enum logic [1:0] {IDLE, PENDING, SERVING} req_state_t;
endpackage

// File: rtl/traf_debounce.sv
// traf_debounce: 2-flop synchroniser, debounce counter, clean level and rise pulse
module traf_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic s1, s2, level_d;
    logic [CW-1:0] cnt;
    logic hit;
    assign hit  = cnt == CW'(DEB_CYCLES - 1);
    assign rise = level & ~level_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            level_d <= level;
            if (s2 != level) begin
                level <= hit ? ~level : level;
                cnt   <= hit ? '0 : cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/traf_sensor_req.sv
// traf_sensor_req: debounced car/pedestrian inputs turned into a latched side-road request with wait age
module traf_sensor_req
    import traf_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int AGE_W      = 8,
    parameter int MAX_WAIT   = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             car_raw,
    input  logic             ped_raw,
    input  logic [1:0]       side,
    output logic             car_present,
    output logic             side_req,
    output logic             ped_req,
    output logic [AGE_W-1:0] req_age,
    output logic             starve
);
    localparam logic [AGE_W-1:0] MAX_W = AGE_W'(MAX_WAIT);
    req_state_t state, state_nxt;
    logic car_rise, ped_rise, ped_level, green, red, ped_nxt;
    logic [AGE_W-1:0] age_nxt;
    traf_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_car (
        .clk(clk), .rst_n(rst_n), .raw(car_raw), .level(car_present), .rise(car_rise)
    );
    traf_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ped (
        .clk(clk), .rst_n(rst_n), .raw(ped_raw), .level(ped_level), .rise(ped_rise)
    );
    assign green    = side == LT_GREEN;
    assign red      = side == LT_RED || side == 2'b11;
    assign side_req = state == PENDING;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (car_rise || ped_rise) ? PENDING : IDLE;
            PENDING: state_nxt = green ? SERVING : PENDING;
            SERVING: state_nxt = !red ? SERVING : car_present ? PENDING : IDLE;
            default: state_nxt = IDLE;
        endcase
        ped_nxt = green ? 1'b0 : (ped_rise && ped_level && state != SERVING) ? 1'b1 : ped_req;
        age_nxt = (state == PENDING && state_nxt == PENDING) ? ((&req_age) ? req_age : req_age + 1'b1) : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ped_req <= 1'b0;
            req_age <= '0;
            starve  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ped_req <= ped_nxt;
            req_age <= age_nxt;
            starve  <= state_nxt == PENDING && age_nxt >= MAX_W;
        end
    end
endmodule
